tmr0_wdt_presc: RTL and testbench
=================================

TMR0_WDT_PRESC -- requirements
Module: tmr0_wdt_presc

Interface
REQ-001 SHALL have parameter WDT_BASE, default 4096, meaning the number of clk cycles per watchdog base tick (legal range 2..65536).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, one instruction cycle per edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port option_in, input, 8 bits: the OPTION register value. Fields: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS.
REQ-005 SHALL have port t0cki, input, 1 bit: external TMR0 clock pin, asynchronous to clk.
REQ-006 SHALL have port tmr0_wr, input, 1 bit: one-cycle pulse indicating that TMR0 is being written.
REQ-007 SHALL have ports clrwdt and sleep, input, 1 bit each: one-cycle pulses decoded from the CLRWDT and SLEEP instructions.
REQ-008 SHALL have port tmr0_inc, output, 1 bit: one-cycle TMR0 increment pulse, feeding the register file.
REQ-009 SHALL have port wdtmr, output, 1 bit: one-cycle watchdog time-out pulse.
REQ-010 SHALL have port presc_out, output, 8 bits: current prescaler count, for observation.

Function
REQ-011 SHALL compute the TMR0 source tick as follows:
- T0CS=0: every clk cycle.
- T0CS=1: a t0cki edge after a two-flop synchronizer plus an edge-detect flop.
- T0SE=0 selects the rising edge; T0SE=1 selects the falling edge.
REQ-012 SHALL form the WDT base tick from a counter wdt_base that runs 0..WDT_BASE-1 and wraps to 0. The tick occurs in the cycle the counter equals WDT_BASE-1.
REQ-013 SHALL share one 8-bit prescaler counter. PSA=0 assigns it to TMR0; PSA=1 assigns it to WDT.
REQ-014 With PSA=0, the prescaler SHALL behave as follows:
- It increments on each TMR0 source tick.
- When a tick arrives with count = 2^(PS+1)-1, the count wraps to 0 and tmr0_inc pulses in the next cycle.
- This gives a 1:2 to 1:256 ratio.
- WDT time-out occurs on every base tick.
REQ-015 With PSA=1, the behaviour SHALL be:
- tmr0_inc pulses in the cycle after each source tick (1:1).
- The prescaler increments on each WDT base tick.
- When a base tick arrives with count = 2^PS-1, the count wraps and wdtmr pulses in the next cycle.
- This gives a 1:1 to 1:128 ratio.
REQ-016 SHALL register both outputs, giving a latency of exactly one clk cycle from the qualifying tick to the pulse.
REQ-017 SHALL clear wdt_base on clrwdt or sleep. If PSA=1, the prescaler SHALL also be cleared.
REQ-018 SHALL clear the prescaler on tmr0_wr when PSA=0.
REQ-019 SHALL keep a registered copy psa_q and clear the prescaler in any cycle where option_in[3] differs from psa_q.
REQ-020 SHALL let a clear win over a simultaneous terminal tick (clrwdt/sleep vs WDT, tmr0_wr vs TMR0), suppressing the pulse.
REQ-021 SHALL leave PS changes mid-count uncleared: the new terminal value applies from the next tick. If the count is already above the new terminal value, it runs to 255 and wraps.
REQ-022 SHALL never assert tmr0_inc or wdtmr for more than one consecutive cycle per qualifying tick.

Reset
REQ-023 While rst=0, the block SHALL hold:
- wdt_base = 0, prescaler = 0.
- Synchronizer and edge flops = 0.
- psa_q = 1, matching the OPTION reset value 8'hFF.
- tmr0_inc = 0, wdtmr = 0, presc_out = 0.
REQ-024 SHALL discard any pending pulse if reset is asserted mid-operation. The first possible wdtmr after release SHALL occur no earlier than WDT_BASE cycles later.

Configuration
REQ-025 SHALL support macro TMR0_EXT_CLK_EN:
- Defined: T0CS/T0SE and t0cki are functional as in REQ-011.
- Undefined: the synchronizer is not built, t0cki and T0CS/T0SE are ignored, and the TMR0 source tick is every clk cycle.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Prescaler to TMR0: option_in=8'h01 (T0CS=0, PSA=0, PS=1), run 16 cycles -> tmr0_inc pulses every 4th cycle, exactly 4 pulses; presc_out cycles 0,1,2,3.
- Prescaler to WDT: WDT_BASE=8, option_in=8'h0A (PSA=1, PS=2) -> wdtmr pulses once every 32 cycles; tmr0_inc pulses every cycle.
- Watchdog clear: WDT_BASE=8, PSA=1, PS=0, clrwdt in the same cycle as wdt_base=7 -> no wdtmr; the next wdtmr occurs 8 cycles later.
- External clock: TMR0_EXT_CLK_EN defined, option_in=8'h38 (T0CS=1, T0SE=1, PSA=1), 5 falling t0cki edges spaced 6 clk apart -> 5 tmr0_inc pulses, each 3-4 cycles after its edge. With the macro undefined -> tmr0_inc every cycle.
- PSA switch and tmr0_wr:
  - Presc at 5 with PSA=0, then flip PSA to 1 -> presc_out = 0 next cycle.
  - PSA=0, tmr0_wr coincident with terminal tick -> no tmr0_inc, presc_out = 0.
- Reset mid-count: rst low for 1 cycle with presc=3 and a pulse pending -> all outputs 0; the pulse is never emitted.

Source files
------------

// File: rtl/tmr0_wdt_presc.sv
// TMR0 / watchdog shared 8-bit prescaler with registered tick outputs.
// Define TMR0_EXT_CLK_EN to build the t0cki synchronizer and honour T0CS/T0SE.
module tmr0_wdt_presc #(
    parameter int unsigned WDT_BASE = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] option_in,
    input  logic       t0cki,
    input  logic       tmr0_wr,
    input  logic       clrwdt,
    input  logic       sleep,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic [7:0] presc_out
);

    localparam int unsigned WDT_W = $clog2(WDT_BASE);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_BASE - 1);

    logic [WDT_W-1:0] wdt_base_q, wdt_base_d;
    logic [7:0]       presc_q, presc_d;
    logic             psa_q;
    logic             tmr0_inc_q, tmr0_inc_d;
    logic             wdtmr_q, wdtmr_d;

    logic       src_tick_c;
    logic       wdt_tick_c;
    logic       psa_c;
    logic       psa_chg_c;
    logic       wdt_clr_c;
    logic [8:0] tmr_span_c, wdt_span_c;
    logic [7:0] tmr_term_c, wdt_term_c;

`ifdef TMR0_EXT_CLK_EN
    logic sync1_q, sync2_q, edge_q;
    logic ext_tick_c;
    logic unused_opt_c;

    // Two-flop synchronizer for t0cki plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= t0cki;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign ext_tick_c   = option_in[4] ? (edge_q & ~sync2_q) : (sync2_q & ~edge_q);
    assign src_tick_c   = option_in[5] ? ext_tick_c : 1'b1;
    assign unused_opt_c = ^option_in[7:6];
`else
    logic unused_opt_c;

    assign src_tick_c   = 1'b1;
    assign unused_opt_c = ^{option_in[7:4], t0cki};
`endif

    assign psa_c      = option_in[3];
    assign psa_chg_c  = psa_c != psa_q;
    assign wdt_clr_c  = clrwdt | sleep;
    assign wdt_tick_c = wdt_base_q == WDT_LAST;

    // Terminal counts: 2^(PS+1)-1 toward TMR0, 2^PS-1 toward the watchdog
    assign tmr_span_c = 9'd2 << option_in[2:0];
    assign wdt_span_c = 9'd1 << option_in[2:0];
    assign tmr_term_c = 8'(tmr_span_c - 9'd1);
    assign wdt_term_c = 8'(wdt_span_c - 9'd1);

    always_comb begin
        wdt_base_d = wdt_tick_c ? '0 : wdt_base_q + WDT_W'(1);
        presc_d    = presc_q;
        tmr0_inc_d = 1'b0;
        wdtmr_d    = 1'b0;

        if (!psa_c) begin
            wdtmr_d = wdt_tick_c;
            if (src_tick_c) begin
                if (presc_q == tmr_term_c) begin
                    presc_d    = '0;
                    tmr0_inc_d = 1'b1;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
        end else begin
            tmr0_inc_d = src_tick_c;
            if (wdt_tick_c) begin
                if (presc_q == wdt_term_c) begin
                    presc_d = '0;
                    wdtmr_d = 1'b1;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
        end

        // Clears take priority over a coincident terminal tick
        if (wdt_clr_c) begin
            wdt_base_d = '0;
            wdtmr_d    = 1'b0;
            if (psa_c) begin
                presc_d = '0;
            end
        end
        if (tmr0_wr && !psa_c) begin
            presc_d    = '0;
            tmr0_inc_d = 1'b0;
        end
        if (psa_chg_c) begin
            presc_d = '0;
            if (psa_c) begin
                wdtmr_d = 1'b0;
            end else begin
                tmr0_inc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_base_q <= '0;
            presc_q    <= '0;
            psa_q      <= 1'b1;
            tmr0_inc_q <= 1'b0;
            wdtmr_q    <= 1'b0;
        end else begin
            wdt_base_q <= wdt_base_d;
            presc_q    <= presc_d;
            psa_q      <= psa_c;
            tmr0_inc_q <= tmr0_inc_d;
            wdtmr_q    <= wdtmr_d;
        end
    end

    assign tmr0_inc  = tmr0_inc_q;
    assign wdtmr     = wdtmr_q;
    assign presc_out = presc_q;

endmodule

// File: tb/tb_tmr0_wdt_presc.sv
// Directed self-checking bench for tmr0_wdt_presc with WDT_BASE = 8.
module tb_tmr0_wdt_presc;

    logic       clk;
    logic       rst;
    logic [7:0] option_in;
    logic       t0cki;
    logic       tmr0_wr;
    logic       clrwdt;
    logic       sleep;
    logic       tmr0_inc;
    logic       wdtmr;
    logic [7:0] presc_out;

    int n_tests;
    int n_fail;

    tmr0_wdt_presc #(.WDT_BASE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .option_in (option_in),
        .t0cki     (t0cki),
        .tmr0_wr   (tmr0_wr),
        .clrwdt    (clrwdt),
        .sleep     (sleep),
        .tmr0_inc  (tmr0_inc),
        .wdtmr     (wdtmr),
        .presc_out (presc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given OPTION value; the next step() is edge 1 after release
    task automatic do_reset(input logic [7:0] opt);
        option_in = opt;
        tmr0_wr   = 1'b0;
        clrwdt    = 1'b0;
        sleep     = 1'b0;
        rst       = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        t0cki = 1'b1;
        do_reset(8'hFF);
        rst = 1'b0;
        #1;
        n_tests++;
        if (tmr0_inc !== 1'b0 || wdtmr !== 1'b0 || presc_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got inc=%b wdt=%b presc=%0d, want 0 0 0",
                     tmr0_inc, wdtmr, presc_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_presc_tmr0();
        int pulses;
        pulses = 0;
        do_reset(8'h01);
        step();
        n_tests++;
        if (presc_out !== 8'd0 || tmr0_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL presc_tmr0_settle: got presc=%0d inc=%b, want 0 0", presc_out, tmr0_inc);
        end
        for (int s = 1; s <= 16; s++) begin
            step();
            if (tmr0_inc === 1'b1) pulses++;
            n_tests++;
            if (presc_out !== 8'(s % 4) || tmr0_inc !== ((s % 4) == 0)) begin
                n_fail++;
                $display("FAIL presc_tmr0 cyc%0d: got presc=%0d inc=%b, want %0d %b",
                         s, presc_out, tmr0_inc, s % 4, (s % 4) == 0);
            end
        end
        n_tests++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL presc_tmr0_count: got %0d pulses, want 4", pulses);
        end
    endtask

    task automatic test_presc_wdt();
        do_reset(8'h0A);
        for (int s = 1; s <= 64; s++) begin
            step();
            n_tests++;
            if (wdtmr !== ((s % 32) == 0) || tmr0_inc !== 1'b1 || presc_out !== 8'((s / 8) % 4)) begin
                n_fail++;
                $display("FAIL presc_wdt cyc%0d: got wdt=%b inc=%b presc=%0d, want %b 1 %0d",
                         s, wdtmr, tmr0_inc, presc_out, (s % 32) == 0, (s / 8) % 4);
            end
        end
        // SLEEP clears the prescaler when it belongs to the watchdog
        for (int s = 1; s <= 18; s++) step();
        sleep = 1'b1;
        step();
        sleep = 1'b0;
        n_tests++;
        if (presc_out !== 8'd0 || wdtmr !== 1'b0) begin
            n_fail++;
            $display("FAIL sleep_clear: got presc=%0d wdt=%b, want 0 0", presc_out, wdtmr);
        end
    endtask

    task automatic test_wdt_clear();
        do_reset(8'h08);
        for (int s = 1; s <= 16; s++) begin
            step();
            clrwdt = (s == 7);
            n_tests++;
            if (wdtmr !== (s == 16)) begin
                n_fail++;
                $display("FAIL wdt_clear cyc%0d: got wdt=%b, want %b", s, wdtmr, s == 16);
            end
        end
        clrwdt = 1'b0;
    endtask

    task automatic test_ext_clk();
`ifdef TMR0_EXT_CLK_EN
        int pulses;
        pulses = 0;
        t0cki  = 1'b1;
        do_reset(8'h38);
        for (int s = 1; s <= 4; s++) begin
            step();
            n_tests++;
            if (tmr0_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_settle cyc%0d: got inc=%b, want 0", s, tmr0_inc);
            end
        end
        for (int e = 0; e < 5; e++) begin
            t0cki = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                step();
                if (tmr0_inc === 1'b1) pulses++;
                n_tests++;
                if (tmr0_inc !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL ext_edge%0d cyc%0d: got inc=%b, want %b", e, k, tmr0_inc, k == 3);
                end
                if (k == 3) t0cki = 1'b1;
            end
        end
        n_tests++;
        if (pulses != 5) begin
            n_fail++;
            $display("FAIL ext_count: got %0d pulses, want 5", pulses);
        end
`else
        t0cki = 1'b1;
        do_reset(8'h38);
        for (int s = 1; s <= 12; s++) begin
            step();
            t0cki = ~t0cki;
            n_tests++;
            if (tmr0_inc !== 1'b1) begin
                n_fail++;
                $display("FAIL ext_disabled cyc%0d: got inc=%b, want 1", s, tmr0_inc);
            end
        end
`endif
    endtask

    task automatic test_psa_switch();
        do_reset(8'h07);
        for (int s = 1; s <= 6; s++) step();
        n_tests++;
        if (presc_out !== 8'd5) begin
            n_fail++;
            $display("FAIL psa_pre: got presc=%0d, want 5", presc_out);
        end
        option_in = 8'h0F;
        step();
        n_tests++;
        if (presc_out !== 8'd0) begin
            n_fail++;
            $display("FAIL psa_switch: got presc=%0d, want 0", presc_out);
        end
    endtask

    task automatic test_tmr0_wr();
        do_reset(8'h01);
        for (int s = 1; s <= 4; s++) step();
        n_tests++;
        if (presc_out !== 8'd3) begin
            n_fail++;
            $display("FAIL tmr0_wr_pre: got presc=%0d, want 3", presc_out);
        end
        tmr0_wr = 1'b1;
        step();
        tmr0_wr = 1'b0;
        n_tests++;
        if (tmr0_inc !== 1'b0 || presc_out !== 8'd0) begin
            n_fail++;
            $display("FAIL tmr0_wr_clear: got inc=%b presc=%0d, want 0 0", tmr0_inc, presc_out);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++;
            if (tmr0_inc !== (k == 4) || presc_out !== 8'(k % 4)) begin
                n_fail++;
                $display("FAIL tmr0_wr_after cyc%0d: got inc=%b presc=%0d, want %b %0d",
                         k, tmr0_inc, presc_out, k == 4, k % 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(8'h01);
        for (int s = 1; s <= 4; s++) step();
        n_tests++;
        if (presc_out !== 8'd3) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got presc=%0d, want 3", presc_out);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (tmr0_inc !== 1'b0 || wdtmr !== 1'b0 || presc_out !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got inc=%b wdt=%b presc=%0d, want 0 0 0",
                     tmr0_inc, wdtmr, presc_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            n_tests++;
            if (tmr0_inc !== (s == 5) || wdtmr !== (s == 8) || presc_out !== 8'((s - 1) % 4)) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc%0d: got inc=%b wdt=%b presc=%0d, want %b %b %0d",
                         s, tmr0_inc, wdtmr, presc_out, s == 5, s == 8, (s - 1) % 4);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        option_in = 8'hFF;
        t0cki     = 1'b1;
        tmr0_wr   = 1'b0;
        clrwdt    = 1'b0;
        sleep     = 1'b0;
        test_reset();
        test_presc_tmr0();
        test_presc_wdt();
        test_wdt_clear();
        test_ext_clk();
        test_psa_switch();
        test_tmr0_wr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
